// File: rtl/y86_dmem_stage_if.sv
// Request/response bundle between execute, the data-memory stage and write-back.
// The master side drives requests and accepts responses; the slave side is the stage.
interface y86_dmem_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valM;
    logic        dmem_error;

    modport master (
        output in_valid, icode, valA, valE, valP, out_ready,
        input  in_ready, out_valid, valM, dmem_error
    );

    modport slave (
        input  in_valid, icode, valA, valE, valP, out_ready,
        output in_ready, out_valid, valM, dmem_error
    );
endinterface

// File: rtl/y86_dmem_stage.sv
// Y86-64 data-memory stage: icode decode, one 64-bit access per accepted request,
// and a registered valM/dmem_error response behind a valid/ready handshake.
module y86_dmem_stage #(
    parameter int DEPTH_WORDS = 2048,
    parameter int READ_LAT    = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic             clk,
    input  logic             reset,
    y86_dmem_stage_if.slave  bus
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd8;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_read_lat
        $error("y86_dmem_stage: READ_LAT must be 1 or 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               is_wr_s;
    logic               is_rd_s;
    logic               err_s;
    logic [63:0]        addr_s;
    logic [63:0]        wdata_s;
    logic [63:0]        rd_word_s;
    logic [IDX_W-1:0]   idx_s;
    logic               out_valid_r;
    logic [63:0]        valm_r;
    logic               err_r;
    logic [63:0]        mem_r [DEPTH_WORDS];

    // Beyond the array end, or not on a word boundary when alignment is enforced.
    function automatic logic addr_illegal(input logic [63:0] a);
        return (a >= BYTE_LIMIT) || ((ALIGN_CHECK != 0) && (a[2:0] != 3'd0));
    endfunction

    // Decode icode into access kind, byte address and store data.
    always_comb begin
        is_wr_s = 1'b0;
        is_rd_s = 1'b0;
        addr_s  = 64'd0;
        wdata_s = 64'd0;
        case (bus.icode)
            I_RMMOVQ, I_PUSHQ: begin
                is_wr_s = 1'b1;
                addr_s  = bus.valE;
                wdata_s = bus.valA;
            end
            I_CALL: begin
                is_wr_s = 1'b1;
                addr_s  = bus.valE;
                wdata_s = bus.valP;
            end
            I_MRMOVQ: begin
                is_rd_s = 1'b1;
                addr_s  = bus.valE;
            end
            I_RET, I_POPQ: begin
                is_rd_s = 1'b1;
                addr_s  = bus.valA;
            end
            default: begin
                is_wr_s = 1'b0;
                is_rd_s = 1'b0;
            end
        endcase
    end

    assign err_s    = (is_wr_s || is_rd_s) && addr_illegal(addr_s);
    assign idx_s    = addr_s[IDX_W+2:3];
    assign accept_s = bus.in_valid && in_ready_s;

    // Read word seen by the response register; zero for non-reads and errors.
    always_comb begin
        rd_word_s = 64'd0;
        if (is_rd_s && !err_s) begin
            rd_word_s = mem_r[idx_s];
        end else begin
            rd_word_s = 64'd0;
        end
    end

    // Upstream readiness depends only on the state and downstream readiness.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_WAIT: in_ready_s = 1'b0;
            ST_RESP: in_ready_s = bus.out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Next-state logic; RESP hands off and re-accepts on the same edge.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = (READ_LAT == 2) ? ST_WAIT : ST_RESP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: state_nx_s = ST_RESP;
            ST_RESP: begin
                if (bus.out_ready && accept_s) begin
                    state_nx_s = (READ_LAT == 2) ? ST_WAIT : ST_RESP;
                end else if (bus.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State and response registers; the response is loaded on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            valm_r      <= 64'd0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= (state_nx_s == ST_RESP);
            if (accept_s) begin
                valm_r <= rd_word_s;
                err_r  <= err_s;
            end
        end
    end

    // Storage array, not reset; illegal stores are dropped.
    always_ff @(posedge clk) begin
        if (!reset && accept_s && is_wr_s && !err_s) begin
            mem_r[idx_s] <= wdata_s;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.valM       = valm_r;
    assign bus.dmem_error = err_r;
endmodule

// File: tb/tb_y86_dmem_stage.sv
// Bench for y86_dmem_stage: one READ_LAT=1/ALIGN_CHECK=1 instance and one
// READ_LAT=2/ALIGN_CHECK=0 instance, exercised in turn against a transaction model.
module tb_y86_dmem_stage;
    localparam int DW = 64;

    logic        clk = 1'b0;
    logic        reset;
    bit          sel;
    logic        in_valid_d;
    logic [3:0]  icode_d;
    logic [63:0] a_d, e_d, p_d;
    logic        out_ready;
    int          or_mode;
    bit          chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        ov_m, ir_m, err_m;
    logic [63:0] valm_m;

    logic [63:0] mdl_mem [2][DW];
    logic [63:0] q_v;
    logic        q_e;
    int          q_n = 0;
    longint      q_at = 0;
    longint      edge_cnt = 0;
    logic [3:0]  ic_tab [10];

    y86_dmem_stage_if b1();
    y86_dmem_stage_if b2();

    y86_dmem_stage #(.DEPTH_WORDS(DW), .READ_LAT(1), .ALIGN_CHECK(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1));
    y86_dmem_stage #(.DEPTH_WORDS(DW), .READ_LAT(2), .ALIGN_CHECK(0)) dut2 (
        .clk(clk), .reset(reset), .bus(b2));

    assign b1.in_valid  = (sel == 1'b0) ? in_valid_d : 1'b0;
    assign b2.in_valid  = (sel == 1'b1) ? in_valid_d : 1'b0;
    assign b1.out_ready = (sel == 1'b0) ? out_ready : 1'b1;
    assign b2.out_ready = (sel == 1'b1) ? out_ready : 1'b1;
    assign b1.icode = icode_d;  assign b2.icode = icode_d;
    assign b1.valA  = a_d;      assign b2.valA  = a_d;
    assign b1.valE  = e_d;      assign b2.valE  = e_d;
    assign b1.valP  = p_d;      assign b2.valP  = p_d;

    assign ov_m   = sel ? b2.out_valid  : b1.out_valid;
    assign ir_m   = sel ? b2.in_ready   : b1.in_ready;
    assign err_m  = sel ? b2.dmem_error : b1.dmem_error;
    assign valm_m = sel ? b2.valM       : b1.valM;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Architectural meaning of one request: what it returns, and its effect on memory.
    function automatic void model_access(input int s, input logic [3:0] ic,
                                         input logic [63:0] a, input logic [63:0] e,
                                         input logic [63:0] p,
                                         output logic [63:0] v, output logic er);
        bit wr = 1'b0, rd = 1'b0;
        logic [63:0] ad = 64'd0, wd = 64'd0;
        case (ic)
            4'h4, 4'hA: begin wr = 1'b1; ad = e; wd = a; end
            4'h8:       begin wr = 1'b1; ad = e; wd = p; end
            4'h5:       begin rd = 1'b1; ad = e; end
            4'h9, 4'hB: begin rd = 1'b1; ad = a; end
            default:    begin end
        endcase
        v  = 64'd0;
        er = 1'b0;
        if (wr || rd) begin
            er = (ad >= 64'(DW * 8)) || ((s == 0) && (ad % 64'd8 != 64'd0));
            if (!er && wr) mdl_mem[s][ad / 64'd8] = wd;
            if (!er && rd) v = mdl_mem[s][ad / 64'd8];
        end
    endfunction

    // Per-cycle compare of the selected DUT against the model, then advance the model.
    always @(negedge clk) begin : cmp
        bit          ev, er_i;
        logic [63:0] mv;
        logic        me;
        ev   = (q_n != 0) && (edge_cnt >= q_at);
        er_i = (q_n == 0) ? 1'b1 : (ev ? out_ready : 1'b0);
        if (chk_en) begin
            chk("out_valid", 64'(ov_m), 64'(ev));
            chk("in_ready", 64'(ir_m), 64'(er_i));
            if (ev && ov_m) begin
                chk("valM", valm_m, q_v);
                chk("dmem_error", 64'(err_m), 64'(q_e));
            end
        end
        if (reset) begin
            q_n = 0;
        end else begin
            if (ev && out_ready) q_n = 0;
            if (in_valid_d && er_i) begin
                model_access(int'(sel), icode_d, a_d, e_d, p_d, mv, me);
                q_v  = mv;
                q_e  = me;
                q_at = edge_cnt + (sel ? 2 : 1);
                q_n  = 1;
            end
        end
    end

    // out_ready: random, held high, or held low; updated just after the driver.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (or_mode == 0) out_ready = 1'($urandom_range(0, 1));
            else              out_ready = (or_mode == 1);
        end
    end

    task automatic send(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] p, output int waits);
        icode_d = ic; a_d = a; e_d = e; p_d = p;
        in_valid_d = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (ir_m) begin
                @(posedge clk); #1;
                in_valid_d = 1'b0;
                break;
            end
            @(posedge clk); #1;
            waits++;
            if (waits > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: no accept after %0d cycles, required accept", waits);
                in_valid_d = 1'b0;
                break;
            end
        end
    endtask

    task automatic expect_resp(input logic [63:0] ev, input logic ee, input int lat,
                               input string nm);
        int w = 0;
        forever begin
            @(negedge clk);
            if (ov_m && out_ready) begin
                chk({nm, "_valM"}, valm_m, ev);
                chk({nm, "_err"}, 64'(err_m), 64'(ee));
                chk({nm, "_lat"}, 64'(w), 64'(lat - 1));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            w++;
            if (w > 20) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_timeout: no response after %0d cycles, required response", nm, w);
                break;
            end
        end
    endtask

    task automatic do_req(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                          input logic [63:0] p, input logic [63:0] ev, input logic ee,
                          input string nm);
        int w;
        send(ic, a, e, p, w);
        expect_resp(ev, ee, sel ? 2 : 1, nm);
    endtask

    task automatic drain();
        or_mode = 1;
        for (int i = 0; i < 60; i++) begin
            if (q_n == 0 && !ov_m) break;
            @(posedge clk); #1;
            if (i == 59) begin
                n_cmp++; n_bad++;
                $display("FAIL drain_timeout: response still pending, required none");
            end
        end
    endtask

    task automatic init_mem();
        int w;
        or_mode = 1;
        for (int k = 0; k < DW; k++) send(4'h4, {$urandom, $urandom}, 64'(k) * 64'd8, 64'd0, w);
        drain();
    endtask

    task automatic random_phase(input int n);
        int w, r, gap;
        logic [63:0] ad, a, e, p;
        logic [3:0]  ic;
        or_mode = 0;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            if (gap == 3) begin @(posedge clk); #1; end
            ic = ic_tab[$urandom_range(0, 9)];
            r  = $urandom_range(0, 9);
            if (r < 7)       ad = 64'($urandom_range(0, DW - 1)) * 64'd8;
            else if (r == 7) ad = 64'($urandom_range(0, DW - 1)) * 64'd8 + 64'($urandom_range(1, 7));
            else if (r == 8) ad = 64'(DW * 8) + 64'($urandom_range(0, 64)) * 64'd8;
            else             ad = {$urandom, $urandom};
            a = {$urandom, $urandom}; e = {$urandom, $urandom}; p = {$urandom, $urandom};
            if (ic == 4'h4 || ic == 4'hA || ic == 4'h8 || ic == 4'h5) e = ad;
            if (ic == 4'h9 || ic == 4'hB) a = ad;
            send(ic, a, e, p, w);
        end
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        ic_tab[0] = 4'h4; ic_tab[1] = 4'h5; ic_tab[2] = 4'h8; ic_tab[3] = 4'h9;
        ic_tab[4] = 4'hA; ic_tab[5] = 4'hB; ic_tab[6] = 4'h5; ic_tab[7] = 4'hB;
        ic_tab[8] = 4'h0; ic_tab[9] = 4'h6;
        sel = 1'b0; in_valid_d = 1'b0; icode_d = 4'h0;
        a_d = 64'd0; e_d = 64'd0; p_d = 64'd0;
        or_mode = 1; out_ready = 1'b1; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid1", 64'(b1.out_valid), 64'd0);
        chk("rst_in_ready1", 64'(b1.in_ready), 64'd1);
        chk("rst_valM1", b1.valM, 64'd0);
        chk("rst_err1", 64'(b1.dmem_error), 64'd0);
        chk("rst_out_valid2", 64'(b2.out_valid), 64'd0);
        chk("rst_in_ready2", 64'(b2.in_ready), 64'd1);
        @(posedge clk); #1;

        // READ_LAT=1 instance
        init_mem();
        do_req(4'h4, 64'h1122334455667788, 64'h40, 64'd0, 64'd0, 1'b0, "rmmovq_40");
        do_req(4'h5, 64'd0, 64'h40, 64'd0, 64'h1122334455667788, 1'b0, "mrmovq_40");
        do_req(4'h8, 64'd7, 64'h1F8, 64'h123, 64'd0, 1'b0, "call_1f8");
        do_req(4'h9, 64'h1F8, 64'd0, 64'd0, 64'h123, 1'b0, "ret_1f8");
        do_req(4'hB, 64'h1F8, 64'h40, 64'd0, 64'h123, 1'b0, "popq_1f8");
        do_req(4'hA, 64'h5A5A, 64'h100, 64'd0, 64'd0, 1'b0, "pushq_100");
        do_req(4'h5, 64'd0, 64'h100, 64'd0, 64'h5A5A, 1'b0, "mrmovq_100");
        do_req(4'h5, 64'd0, 64'(DW * 8), 64'd0, 64'd0, 1'b1, "mrmovq_oor");
        do_req(4'h4, 64'hDEAD, 64'h44, 64'd0, 64'd0, 1'b1, "rmmovq_mis");
        do_req(4'h5, 64'd0, 64'h40, 64'd0, 64'h1122334455667788, 1'b0, "reread_40");
        do_req(4'h1, 64'h1F8, 64'h40, 64'd0, 64'd0, 1'b0, "nop");

        // Backpressure: three frozen cycles, then release accepts immediately.
        or_mode = 2;
        send(4'h5, 64'd0, 64'h40, 64'd0, w);
        icode_d = 4'h5; e_d = 64'h1F8; in_valid_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(ir_m), 64'd0);
            chk("bp_out_valid", 64'(ov_m), 64'd1);
            chk("bp_valM", valm_m, 64'h1122334455667788);
            @(posedge clk); #1;
        end
        or_mode = 1;
        send(4'h5, 64'd0, 64'h1F8, 64'd0, w);
        chk("bp_release_waits", 64'(w), 64'd0);
        expect_resp(64'h123, 1'b0, 1, "bp_second");
        random_phase(200);

        // READ_LAT=2 instance
        sel = 1'b1;
        init_mem();
        do_req(4'h4, 64'hA5A5A5A5_0F0F0F0F, 64'h80, 64'd0, 64'd0, 1'b0, "l2_w80");
        do_req(4'h5, 64'd0, 64'h80, 64'd0, 64'hA5A5A5A5_0F0F0F0F, 1'b0, "l2_r80");
        do_req(4'h5, 64'd0, 64'h83, 64'd0, 64'hA5A5A5A5_0F0F0F0F, 1'b0, "l2_noalign");
        for (int k = 0; k < 4; k++) begin
            send(4'h5, 64'd0, 64'h80 + 64'(k) * 64'd8, 64'd0, w);
            if (k > 0) chk("l2_b2b_waits", 64'(w), 64'd1);
        end
        drain();

        // Reset while a read sits in WAIT.
        do_req(4'h4, 64'hCAFEF00D12345678, 64'h28, 64'd0, 64'd0, 1'b0, "l2_w28");
        send(4'h5, 64'd0, 64'h28, 64'd0, w);
        reset = 1'b1;
        @(negedge clk);
        chk("wait_in_ready", 64'(ir_m), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(ov_m), 64'd0);
        chk("post_rst_in_ready", 64'(ir_m), 64'd1);
        @(posedge clk); #1;
        do_req(4'h5, 64'd0, 64'h28, 64'd0, 64'hCAFEF00D12345678, 1'b0, "post_rst_r28");
        random_phase(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
